lcd_slideshow_display: RTL and testbench

LCD_SLIDESHOW_DISPLAY -- requirements
Module: lcd_slideshow_display

---
 rtl/lcd_slideshow_display.sv | 169 ++++++++++++++++
 tb/tb_lcd_slideshow_display.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_slideshow_display.sv
// rtl/lcd_slideshow_display.sv - 1-bit ROM slideshow streamed as RGB332 words to an LCD writer
//
// After the LCD init sequence has been passed through, streams IMG_W*IMG_H
// 1-bit pixels (8 per ROM byte, MSB first) as {dc=1, RGB332} words to the
// writer. key_next/key_prev queue an image change that is applied only at
// the frame wrap. Define SLIDESHOW_AUTO_EN to add frame-counted auto advance.
//
// Ports:
//   clk_25MHz, rst                        clock, synchronous active-high reset
//   key_next, key_prev                    step requests, acted on at rising edge
//   auto_mode                             auto advance enable (SLIDESHOW_AUTO_EN only)
//   init_done, init_data, en_write_init   init sequencer handoff
//   wr_done                               writer accepted the current word
//   data, en_write                        word (bit8 = dc) and write request
//   rom_image_id, rom_addr, rom_data      image ROM, data valid 1 cycle after address
//   current_image_id, display_active, frame_done   status
module lcd_slideshow_display #(
   parameter int         IMG_W       = 240,
   parameter int         IMG_H       = 160,
   parameter int         NUM_IMAGES  = 5,
   parameter logic [7:0] FG_RGB332   = 8'hFF,
   parameter logic [7:0] BG_RGB332   = 8'h00,
   parameter int         AUTO_FRAMES = 30
) (
   input  logic        clk_25MHz,
   input  logic        rst,
   input  logic        key_next,
   input  logic        key_prev,
   input  logic        auto_mode,
   input  logic        init_done,
   input  logic [8:0]  init_data,
   input  logic        en_write_init,
   input  logic        wr_done,
   output logic [8:0]  data,
   output logic        en_write,
   output logic [2:0]  rom_image_id,
   output logic [14:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic [2:0]  current_image_id,
   output logic        display_active,
   output logic        frame_done
);

   localparam int            NUM_PIX  = IMG_W * IMG_H;
   localparam int            PW       = $clog2(NUM_PIX);
   localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIX - 1);
   localparam logic [2:0]    LAST_IMG = 3'(NUM_IMAGES - 1);

   typedef enum logic [2:0] {IDLE, INIT, FETCH, WAIT_ROM, WRITE} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] pix;
   logic [7:0]    byte_reg;
   logic [2:0]    image_id, image_nxt, image_fwd, image_back;
   logic          key_next_q, key_prev_q;
   logic          next_edge, prev_edge, key_edge;
   logic          pend_valid, pend_next;
   logic          pix_last, wrap, pix_bit;

   assign pix_last   = (pix == LAST_PIX);
   assign wrap       = (state == WRITE) && wr_done && pix_last;
   assign next_edge  = key_next & ~key_next_q;
   assign prev_edge  = key_prev & ~key_prev_q;
   // simultaneous edges on both keys cancel out
   assign key_edge   = next_edge ^ prev_edge;
   assign image_fwd  = (image_id == LAST_IMG) ? 3'd0 : image_id + 3'd1;
   assign image_back = (image_id == 3'd0) ? LAST_IMG : image_id - 3'd1;

   assign rom_addr         = 15'(pix[PW-1:3]);
   assign rom_image_id     = image_id;
   assign current_image_id = image_id;
   assign display_active   = (state == FETCH) || (state == WAIT_ROM) || (state == WRITE);
   assign pix_bit          = byte_reg[3'd7 - pix[2:0]];

`ifdef SLIDESHOW_AUTO_EN
   localparam int AW = $clog2(AUTO_FRAMES + 1);
   logic [AW-1:0] auto_cnt;
   logic          auto_hit;

   // true on the frame whose wrap brings the count up to AUTO_FRAMES
   assign auto_hit = (auto_cnt == AW'(AUTO_FRAMES - 1));

   always_ff @(posedge clk_25MHz) begin
      if (rst || !auto_mode) begin
         auto_cnt <= '0;
      end else if (wrap) begin
         if (pend_valid || auto_hit)
            auto_cnt <= '0;
         else
            auto_cnt <= auto_cnt + AW'(1);
      end
   end
`else
   logic unused_auto_mode;
   assign unused_auto_mode = auto_mode;
`endif

   // image changes only at a wrap; a key request wins over auto advance
   always_comb begin
      image_nxt = image_id;
      if (wrap) begin
         if (pend_valid)
            image_nxt = pend_next ? image_fwd : image_back;
`ifdef SLIDESHOW_AUTO_EN
         else if (auto_mode && auto_hit)
            image_nxt = image_fwd;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     state_nxt = INIT;
         INIT:     if (init_done) state_nxt = FETCH;
         FETCH:    state_nxt = WAIT_ROM;
         WAIT_ROM: state_nxt = WRITE;
         WRITE: begin
            // a new byte is needed when the next pixel starts a byte or the frame wraps
            if (wr_done && (pix_last || pix[2:0] == 3'd7))
               state_nxt = FETCH;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      en_write = 1'b0;
      data     = {1'b1, pix_bit ? FG_RGB332 : BG_RGB332};
      if (state == INIT) begin
         data     = init_data;
         en_write = en_write_init;
      end else if (state == WRITE) begin
         en_write = 1'b1;
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (rst) begin
         state      <= IDLE;
         pix        <= '0;
         byte_reg   <= '0;
         image_id   <= '0;
         key_next_q <= 1'b0;
         key_prev_q <= 1'b0;
         pend_valid <= 1'b0;
         pend_next  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         key_next_q <= key_next;
         key_prev_q <= key_prev;
         frame_done <= wrap;
         image_id   <= image_nxt;
         if (state == WAIT_ROM)
            byte_reg <= rom_data;
         if (state == WRITE && wr_done)
            pix <= pix_last ? '0 : pix + PW'(1);
         // a new edge at the wrap cycle is kept for the following frame
         if (key_edge) begin
            pend_valid <= 1'b1;
            pend_next  <= next_edge;
         end else if (wrap) begin
            pend_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcd_slideshow_display.sv
// tb/tb_lcd_slideshow_display.sv - directed self-checking bench for lcd_slideshow_display
module tb_lcd_slideshow_display;

   localparam int W    = 120;
   localparam int H    = 104;
   localparam int NPIX = W * H;

   logic        clk_25MHz = 1'b0;
   logic        rst, key_next, key_prev, auto_mode, init_done, en_write_init;
   logic [8:0]  init_data, data;
   logic        wr_done, en_write, display_active, frame_done;
   logic [2:0]  rom_image_id, current_image_id;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data;

   logic        fast;
   logic        wr_done_q = 1'b0;
   int          passed = 0;
   int          total  = 0;
   int          frame_pix = 0;
   int          unstable = 0;
   logic        prev_hold = 1'b0;
   logic [8:0]  prev_data = '0;
   logic [8:0]  first_words [0:15];

   always #20 clk_25MHz = ~clk_25MHz;

   lcd_slideshow_display #(
      .IMG_W(W), .IMG_H(H), .NUM_IMAGES(5), .AUTO_FRAMES(2)
   ) dut (
      .clk_25MHz(clk_25MHz), .rst(rst), .key_next(key_next), .key_prev(key_prev),
      .auto_mode(auto_mode), .init_done(init_done), .init_data(init_data),
      .en_write_init(en_write_init), .wr_done(wr_done), .data(data), .en_write(en_write),
      .rom_image_id(rom_image_id), .rom_addr(rom_addr), .rom_data(rom_data),
      .current_image_id(current_image_id), .display_active(display_active),
      .frame_done(frame_done)
   );

   function automatic logic [7:0] rom_byte(input logic [2:0] id, input logic [14:0] a);
      if (a == 15'd0) return 8'hA0 ^ {5'd0, id};
      return a[7:0] ^ {id, 5'd0};
   endfunction

   always @(posedge clk_25MHz) rom_data <= rom_byte(rom_image_id, rom_addr);

   // slow writer: wr_done one cycle after en_write; fast writer: same cycle
   always @(posedge clk_25MHz) wr_done_q <= en_write && !wr_done_q && !fast && display_active;
   assign wr_done = fast ? (en_write && display_active) : wr_done_q;

   always @(negedge clk_25MHz) begin
      if (rst || frame_done) begin
         frame_pix <= 0;
      end else if (en_write && wr_done && display_active) begin
         if (frame_pix < 16) first_words[frame_pix] <= data;
         frame_pix <= frame_pix + 1;
      end
      if (display_active && prev_hold && en_write && data !== prev_data)
         unstable <= unstable + 1;
      prev_hold <= en_write && !wr_done && display_active;
      prev_data <= data;
   end

   task automatic wait_frame_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk_25MHz);
         if (frame_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse(input logic nxt, input logic prv);
      key_next = nxt;
      key_prev = prv;
      @(negedge clk_25MHz);
      key_next = 1'b0;
      key_prev = 1'b0;
      @(negedge clk_25MHz);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk_25MHz);
      total++; if ({en_write, display_active, frame_done} !== 3'b000)
         $display("FAIL reset_flags: got %b expected 000", {en_write, display_active, frame_done}); else passed++;
      total++; if (rom_addr !== 15'd0)
         $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); else passed++;
      total++; if (current_image_id !== 3'd0)
         $display("FAIL reset_image: got %0d expected 0", current_image_id); else passed++;
   endtask

   task automatic test_init();
      rst = 1'b0;
      @(negedge clk_25MHz);
      en_write_init = 1'b1;
      init_data     = 9'h0A5;
      #1;
      total++; if ({en_write, data} !== {1'b1, 9'h0A5})
         $display("FAIL init_passthrough: got en=%b data=%h expected en=1 data=0a5", en_write, data); else passed++;
      @(negedge clk_25MHz);
      en_write_init = 1'b0;
      repeat (7) @(negedge clk_25MHz);
      total++; if (display_active !== 1'b0)
         $display("FAIL init_inactive: got %b expected 0", display_active); else passed++;
      init_done = 1'b1;
      @(negedge clk_25MHz);
      total++; if ({display_active, en_write} !== 2'b10)
         $display("FAIL fetch_entry: got active/en=%b expected 10", {display_active, en_write}); else passed++;
      @(negedge clk_25MHz);
      total++; if (en_write !== 1'b0)
         $display("FAIL fetch_plus1_en: got %b expected 0", en_write); else passed++;
      @(negedge clk_25MHz);
      total++; if (en_write !== 1'b1)
         $display("FAIL fetch_plus2_en: got %b expected 1", en_write); else passed++;
      total++; if ({current_image_id, rom_image_id} !== 6'd0)
         $display("FAIL first_image: got %0d/%0d expected 0/0", current_image_id, rom_image_id); else passed++;
   endtask

   task automatic test_pixels();
      logic [8:0] exp_words [0:8];
      exp_words = '{9'h1FF, 9'h100, 9'h1FF, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100, 9'h100};
      for (int i = 0; i < 200 && frame_pix < 16; i++) @(negedge clk_25MHz);
      total++; if (frame_pix < 16)
         $display("FAIL pixel_timeout: got %0d pixels expected 16", frame_pix); else passed++;
      for (int i = 0; i < 9; i++) begin
         total++; if (first_words[i] !== exp_words[i])
            $display("FAIL pixel_%0d: got %h expected %h", i, first_words[i], exp_words[i]); else passed++;
      end
      total++; if (first_words[15] !== 9'h1FF)
         $display("FAIL pixel_15: got %h expected 1ff", first_words[15]); else passed++;
      total++; if (unstable !== 0)
         $display("FAIL data_hold: got %0d changes expected 0", unstable); else passed++;
      fast = 1'b1;
   endtask

   task automatic test_key_prev();
      bit ok;
      pulse(1'b0, 1'b1);
      repeat (50) @(negedge clk_25MHz);
      total++; if (current_image_id !== 3'd0)
         $display("FAIL prev_midframe: got %0d expected 0", current_image_id); else passed++;
      wait_frame_done(ok);
      total++; if (!ok) $display("FAIL frame_a_timeout: got none expected frame_done"); else passed++;
      total++; if (frame_pix !== NPIX)
         $display("FAIL frame_length: got %0d expected %0d", frame_pix, NPIX); else passed++;
      total++; if ({current_image_id, rom_image_id} !== {3'd4, 3'd4})
         $display("FAIL prev_wrap: got %0d/%0d expected 4/4", current_image_id, rom_image_id); else passed++;
      @(negedge clk_25MHz);
      total++; if (frame_done !== 1'b0)
         $display("FAIL frame_done_pulse: got %b expected 0", frame_done); else passed++;
   endtask

   task automatic test_key_next();
      bit ok;
      repeat (100) @(negedge clk_25MHz);
      pulse(1'b1, 1'b0);
      repeat (100) @(negedge clk_25MHz);
      pulse(1'b1, 1'b0);
      repeat (100) @(negedge clk_25MHz);
      total++; if (current_image_id !== 3'd4)
         $display("FAIL next_midframe: got %0d expected 4", current_image_id); else passed++;
      wait_frame_done(ok);
      total++; if (!ok) $display("FAIL frame_b_timeout: got none expected frame_done"); else passed++;
      total++; if (current_image_id !== 3'd0)
         $display("FAIL next_wrap_single_step: got %0d expected 0", current_image_id); else passed++;
   endtask

   task automatic test_simultaneous_and_auto();
      bit ok;
      logic [2:0] exp_auto;
`ifdef SLIDESHOW_AUTO_EN
      exp_auto = 3'd1;
`else
      exp_auto = 3'd0;
`endif
      auto_mode = 1'b1;
      repeat (100) @(negedge clk_25MHz);
      pulse(1'b1, 1'b1);
      wait_frame_done(ok);
      total++; if (!ok) $display("FAIL frame_c_timeout: got none expected frame_done"); else passed++;
      total++; if (current_image_id !== 3'd0)
         $display("FAIL both_keys_ignored: got %0d expected 0", current_image_id); else passed++;
      wait_frame_done(ok);
      total++; if (!ok) $display("FAIL frame_d_timeout: got none expected frame_done"); else passed++;
      total++; if (current_image_id !== exp_auto)
         $display("FAIL auto_advance: got %0d expected %0d", current_image_id, exp_auto); else passed++;
      auto_mode = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 20000 && frame_pix != 12345; i++) @(negedge clk_25MHz);
      total++; if (frame_pix !== 12345)
         $display("FAIL reach_pixel_12345: got %0d expected 12345", frame_pix); else passed++;
      rst = 1'b1;
      @(negedge clk_25MHz);
      total++; if ({en_write, display_active, frame_done} !== 3'b000)
         $display("FAIL midreset_flags: got %b expected 000", {en_write, display_active, frame_done}); else passed++;
      total++; if (rom_addr !== 15'd0)
         $display("FAIL midreset_rom_addr: got %0d expected 0", rom_addr); else passed++;
      total++; if ({current_image_id, rom_image_id} !== 6'd0)
         $display("FAIL midreset_image: got %0d/%0d expected 0/0", current_image_id, rom_image_id); else passed++;
      rst = 1'b0;
      @(negedge clk_25MHz);
      total++; if (display_active !== 1'b0)
         $display("FAIL redisplay_init: got %b expected 0", display_active); else passed++;
      @(negedge clk_25MHz);
      total++; if ({display_active, rom_addr} !== {1'b1, 15'd0})
         $display("FAIL redisplay_fetch: got active=%b addr=%0d expected active=1 addr=0", display_active, rom_addr); else passed++;
      repeat (2) @(negedge clk_25MHz);
      total++; if ({en_write, data} !== {1'b1, 9'h1FF})
         $display("FAIL redisplay_pixel0: got en=%b data=%h expected en=1 data=1ff", en_write, data); else passed++;
   endtask

   initial begin
      rst           = 1'b1;
      key_next      = 1'b0;
      key_prev      = 1'b0;
      auto_mode     = 1'b0;
      init_done     = 1'b0;
      init_data     = 9'h000;
      en_write_init = 1'b0;
      fast          = 1'b0;
      test_reset();
      test_init();
      test_pixels();
      test_key_prev();
      test_key_next();
      test_simultaneous_and_auto();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
